// File: rtl/line_parser.sv
// line_parser: streaming ASCII parser turning "[lights] (buttons) {joltages}" lines into packed
// records for line_buffer. Define LINE_PARSER_LIGHTS_EN to add the target_lights output.
module line_parser #(
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int MACHINE_COUNT    = 10,
  parameter int BITS_PER_JOLTAGE = 9
) (
  input  logic                                        clk,
  input  logic                                        reset,
  // A byte moves on a rising edge where in_valid and in_ready are both high; the
  // upstream holds in_data steady while in_valid is high and in_ready is low.
  input  logic                                        in_valid,
  input  logic [7:0]                                  in_data,
  output logic                                        in_ready,
  input  logic                                        emit_stall,
  output logic                                        push_element,
  output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]       button_count,
  output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]   flattened_buttons,
  output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]   flattened_machines,
  output logic [15:0]                                 lines_parsed,
  output logic                                        parse_error,
  output logic                                        busy,
`ifdef LINE_PARSER_LIGHTS_EN
  output logic [MACHINE_COUNT-1:0]                    target_lights,
`endif
  output logic [2:0]                                  state_dbg
);

  localparam int BCW = $clog2(MAX_BUTTON_COUNT + 1);
  localparam int JW  = $clog2(MACHINE_COUNT + 1);
  localparam int BW  = MACHINE_COUNT * MAX_BUTTON_COUNT;
  localparam int MW  = MACHINE_COUNT * BITS_PER_JOLTAGE;
  localparam logic [15:0] JOLT_MAX = 16'((1 << BITS_PER_JOLTAGE) - 1);
  localparam logic [15:0] BTN_MAX  = 16'd255;

  typedef enum logic [2:0] {
    S_IDLE, S_LIGHTS, S_BUTTONS, S_BTN_NUM, S_JOLT, S_EMIT, S_SKIP
  } state_t;

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d, busy_q, busy_d, push_q, push_d, err_q, err_d;
  logic [15:0]    lines_q, lines_d, acc_q, acc_d;
  logic [BCW-1:0] bidx_q, bidx_d, count_q, count_d;
  logic [JW-1:0]  jidx_q, jidx_d;
  logic [BW-1:0]  masks_q, masks_d, btn_out_q, btn_out_d;
  logic [MW-1:0]  jolt_q, jolt_d, mach_out_q, mach_out_d;
`ifdef LINE_PARSER_LIGHTS_EN
  logic [JW-1:0]            lcnt_q, lcnt_d;
  logic [MACHINE_COUNT-1:0] lights_q, lights_d, lights_out_q, lights_out_d;
`endif

  logic        xfer, is_digit, is_blank, is_lf, set_bit, store_jolt;
  logic [7:0]  digit;
  logic [15:0] acc_mac;

  always_comb begin
    xfer       = in_valid & in_ready_q;
    is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_lf      = (in_data == 8'h0A);
    is_blank   = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h0D) || is_lf;
    digit      = in_data - 8'h30;
    acc_mac    = (acc_q * 16'd10) + {8'd0, digit};
    state_d    = state_q;
    push_d     = 1'b0;
    err_d      = err_q;
    lines_d    = lines_q;
    acc_d      = acc_q;
    bidx_d     = bidx_q;
    count_d    = count_q;
    jidx_d     = jidx_q;
    masks_d    = masks_q;
    btn_out_d  = btn_out_q;
    jolt_d     = jolt_q;
    mach_out_d = mach_out_q;
    set_bit    = 1'b0;
    store_jolt = 1'b0;
`ifdef LINE_PARSER_LIGHTS_EN
    lcnt_d       = lcnt_q;
    lights_d     = lights_q;
    lights_out_d = lights_out_q;
`endif

    if (state_q == S_EMIT) begin
      if (!emit_stall) begin
        push_d  = 1'b1;
        lines_d = lines_q + 16'd1;
        state_d = S_IDLE;
      end
    end else if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == "[") begin
            acc_d   = '0;
            bidx_d  = '0;
            jidx_d  = '0;
            masks_d = '0;
            jolt_d  = '0;
`ifdef LINE_PARSER_LIGHTS_EN
            lcnt_d   = '0;
            lights_d = '0;
`endif
            state_d = S_LIGHTS;
          end else if (!is_blank) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_LIGHTS: begin
          if (in_data == "." || in_data == "#") begin
`ifdef LINE_PARSER_LIGHTS_EN
            if (lcnt_q < JW'(MACHINE_COUNT)) begin
              for (int k = 0; k < MACHINE_COUNT; k++)
                if (lcnt_q == JW'(k) && in_data == "#") lights_d[k] = 1'b1;
              lcnt_d = lcnt_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
`endif
          end else if (in_data == "]") begin
            state_d = S_BUTTONS;
          end else begin
            err_d   = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_BUTTONS: begin
          if (in_data == "(") begin
            acc_d   = '0;
            state_d = S_BTN_NUM;
          end else if (in_data == "{") begin
            acc_d   = '0;
            jidx_d  = '0;
            state_d = S_JOLT;
          end else if (in_data != " ") begin
            err_d   = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_BTN_NUM: begin
          if (is_digit) begin
            acc_d = (acc_mac > BTN_MAX) ? BTN_MAX : acc_mac;
          end else if (in_data == "," || in_data == ")") begin
            set_bit = 1'b1;
            acc_d   = '0;
            if (in_data == ")") begin
              state_d = S_BUTTONS;
              if (bidx_q < BCW'(MAX_BUTTON_COUNT)) bidx_d = bidx_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_JOLT: begin
          if (is_digit) begin
            if (acc_mac > JOLT_MAX) begin
              acc_d = JOLT_MAX;
              err_d = 1'b1;
            end else begin
              acc_d = acc_mac;
            end
          end else if (in_data == ",") begin
            store_jolt = 1'b1;
            acc_d      = '0;
            if (jidx_q < JW'(MACHINE_COUNT)) jidx_d = jidx_q + 1'b1;
          end else if (in_data == "}") begin
            store_jolt = 1'b1;
            state_d    = S_EMIT;
          end else begin
            err_d   = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_SKIP: if (is_lf) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Out-of-range button indices and buttons past the last slot are dropped but flagged.
    if (set_bit) begin
      if (bidx_q >= BCW'(MAX_BUTTON_COUNT) || acc_q >= 16'(MACHINE_COUNT)) err_d = 1'b1;
      for (int b = 0; b < MAX_BUTTON_COUNT; b++)
        for (int i = 0; i < MACHINE_COUNT; i++)
          if (bidx_q == BCW'(b) && acc_q == 16'(i)) masks_d[b*MACHINE_COUNT + i] = 1'b1;
    end
    if (store_jolt) begin
      if (jidx_q >= JW'(MACHINE_COUNT)) err_d = 1'b1;
      for (int j = 0; j < MACHINE_COUNT; j++)
        if (jidx_q == JW'(j)) jolt_d[j*BITS_PER_JOLTAGE +: BITS_PER_JOLTAGE] = acc_q[BITS_PER_JOLTAGE-1:0];
    end

    // Published outputs only move when a finished line enters EMIT.
    if (state_q == S_JOLT && state_d == S_EMIT) begin
      btn_out_d  = masks_d;
      mach_out_d = jolt_d;
      count_d    = bidx_q;
`ifdef LINE_PARSER_LIGHTS_EN
      lights_out_d = lights_q;
`endif
    end

    in_ready_d = (state_d != S_EMIT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      push_q     <= 1'b0;
      err_q      <= 1'b0;
      lines_q    <= '0;
      acc_q      <= '0;
      bidx_q     <= '0;
      count_q    <= '0;
      jidx_q     <= '0;
      masks_q    <= '0;
      btn_out_q  <= '0;
      jolt_q     <= '0;
      mach_out_q <= '0;
`ifdef LINE_PARSER_LIGHTS_EN
      lcnt_q       <= '0;
      lights_q     <= '0;
      lights_out_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      push_q     <= push_d;
      err_q      <= err_d;
      lines_q    <= lines_d;
      acc_q      <= acc_d;
      bidx_q     <= bidx_d;
      count_q    <= count_d;
      jidx_q     <= jidx_d;
      masks_q    <= masks_d;
      btn_out_q  <= btn_out_d;
      jolt_q     <= jolt_d;
      mach_out_q <= mach_out_d;
`ifdef LINE_PARSER_LIGHTS_EN
      lcnt_q       <= lcnt_d;
      lights_q     <= lights_d;
      lights_out_q <= lights_out_d;
`endif
    end
  end

  assign in_ready           = in_ready_q;
  assign push_element       = push_q;
  assign button_count       = count_q;
  assign flattened_buttons  = btn_out_q;
  assign flattened_machines = mach_out_q;
  assign lines_parsed       = lines_q;
  assign parse_error        = err_q;
  assign busy               = busy_q;
  assign state_dbg          = state_q;
`ifdef LINE_PARSER_LIGHTS_EN
  assign target_lights      = lights_out_q;
`endif

endmodule

// File: tb/tb_line_parser.sv
// tb_line_parser: directed table of parser lines plus stall, mid-line reset and back-to-back sequences.
module tb_line_parser;

  localparam int MBC = 13;
  localparam int MC  = 10;
  localparam int BPJ = 9;
  localparam int BCW = $clog2(MBC + 1);
  localparam int BW  = MC * MBC;
  localparam int MW  = MC * BPJ;
  localparam int W   = BCW + BW + MW + MC;
`ifdef LINE_PARSER_LIGHTS_EN
  localparam bit LIGHTS_ON = 1'b1;
`else
  localparam bit LIGHTS_ON = 1'b0;
`endif

  logic           clk, reset, in_valid, in_ready, emit_stall, push_element, parse_error, busy;
  logic [7:0]     in_data;
  logic [BCW-1:0] button_count;
  logic [BW-1:0]  flattened_buttons;
  logic [MW-1:0]  flattened_machines;
  logic [15:0]    lines_parsed;
  logic [2:0]     state_dbg;
  logic [MC-1:0]  lights_act;
`ifdef LINE_PARSER_LIGHTS_EN
  logic [MC-1:0]  target_lights;
  assign lights_act = target_lights;
`else
  assign lights_act = '0;
`endif

  line_parser #(.MAX_BUTTON_COUNT(MBC), .MACHINE_COUNT(MC), .BITS_PER_JOLTAGE(BPJ)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .emit_stall(emit_stall), .push_element(push_element), .button_count(button_count),
    .flattened_buttons(flattened_buttons), .flattened_machines(flattened_machines),
    .lines_parsed(lines_parsed), .parse_error(parse_error), .busy(busy),
`ifdef LINE_PARSER_LIGHTS_EN
    .target_lights(target_lights),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          s;
    int             pushes;
    int             bc;
    logic [BW-1:0]  masks;
    logic [MW-1:0]  jolts;
    logic [MC-1:0]  lights;
    logic           err;
  } vec_t;

  vec_t           vecs[8];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             n_push = 0;
  logic           push_prev = 1'b0;
  string          line_a = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}";

  function automatic logic [W-1:0] pack_exp(input vec_t v);
    logic [MC-1:0] l;
    l = LIGHTS_ON ? v.lights : '0;
    return {BCW'(v.bc), v.masks, v.jolts, l};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m(input int v, input int b, input logic [MC-1:0] m);
    vecs[v].masks[b*MC +: MC] = m;
  endtask

  task automatic set_j(input int v, input int j, input int val);
    vecs[v].jolts[j*BPJ +: BPJ] = BPJ'(val);
  endtask

  // scoreboard: every push is compared against the oldest expected record
  always @(negedge clk) begin
    if (reset) begin
      push_prev = 1'b0;
    end else begin
      if (push_element) begin
        logic [W-1:0] act, exp;
        n_push++;
        checks++;
        if (push_prev) begin
          errors++;
          $display("FAIL push_width: push high %0d consecutive cycles, required 1", 2);
        end
        act = {button_count, flattened_buttons, flattened_machines, lights_act};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push: got record %h, required no push", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL push_record: got %h required %h", act, exp);
          end
        end
      end
      push_prev = push_element;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout: in_ready 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) begin @(posedge clk); #1; end
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %0d, required 0", busy);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_push;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; emit_stall = 1'b0;

    for (int v = 0; v < 8; v++) begin
      vecs[v].masks = '0; vecs[v].jolts = '0; vecs[v].lights = '0;
      vecs[v].pushes = 1; vecs[v].err = 1'b1;
    end
    vecs[0].s = {line_a, "\n"}; vecs[0].bc = 6; vecs[0].lights = 10'h006; vecs[0].err = 1'b0;
    set_m(0, 0, 10'h008); set_m(0, 1, 10'h00A); set_m(0, 2, 10'h004);
    set_m(0, 3, 10'h00C); set_m(0, 4, 10'h005); set_m(0, 5, 10'h003);
    set_j(0, 0, 3); set_j(0, 1, 5); set_j(0, 2, 4); set_j(0, 3, 7);
    vecs[1].s = "[#.#] (0,9) (5) {0,511,1,1,1,1,1,1,1,9}\n"; vecs[1].bc = 2;
    vecs[1].lights = 10'h005; vecs[1].err = 1'b0;
    set_m(1, 0, 10'h201); set_m(1, 1, 10'h020);
    set_j(1, 1, 511); for (int j = 2; j < 9; j++) set_j(1, j, 1); set_j(1, 9, 9);
    vecs[2].s = "\r\n  [..] {42}\n"; vecs[2].bc = 0; vecs[2].err = 1'b0; set_j(2, 0, 42);
    vecs[3].s = "[#] (12) {600}\n"; vecs[3].bc = 1; vecs[3].lights = 10'h001; set_j(3, 0, 511);
    vecs[4].s = "[.] (1\n"; vecs[4].pushes = 0; vecs[4].bc = 0;
    vecs[5].s = "[#] x\n[#] (0) {1}\n"; vecs[5].bc = 1; vecs[5].lights = 10'h001;
    set_m(5, 0, 10'h001); set_j(5, 0, 1);
    vecs[6].s = "[.] (0) (1) (2) (3) (4) (5) (6) (7) (8) (9) (0) (1) (2) (3) {1}\n"; vecs[6].bc = 13;
    for (int b = 0; b < 10; b++) set_m(6, b, 10'(1 << b));
    set_m(6, 10, 10'h001); set_m(6, 11, 10'h002); set_m(6, 12, 10'h004); set_j(6, 0, 1);
    vecs[7].s = "[.] (0) {1,2,3,4,5,6,7,8,9,10,11}\n"; vecs[7].bc = 1; set_m(7, 0, 10'h001);
    for (int j = 0; j < 10; j++) set_j(7, j, j + 1);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_push", 64'(push_element), 64'd0);
    chk("rst_lines", 64'(lines_parsed), 64'd0);
    chk("rst_error", 64'(parse_error), 64'd0);
    chk("rst_outputs", 64'(|{button_count, flattened_buttons, flattened_machines}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    // table-driven lines
    for (int v = 0; v < 8; v++) begin
      base_push = n_push;
      if (vecs[v].pushes != 0) exp_q.push_back(pack_exp(vecs[v]));
      send_line(vecs[v].s);
      wait_idle();
      chk($sformatf("push_count_%0d", v), 64'(n_push - base_push), 64'(vecs[v].pushes));
      chk($sformatf("parse_error_%0d", v), 64'(parse_error), 64'(vecs[v].err));
      chk($sformatf("missing_push_%0d", v), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    chk("lines_after_table", 64'(lines_parsed), 64'd7);

    // stalled emit: no push and no ready while stall holds
    base_push = n_push;
    emit_stall = 1'b1;
    exp_q.push_back(pack_exp(vecs[0]));
    send_line(line_a);
    for (int c = 0; c < 5; c++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_push", 64'(push_element), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    emit_stall = 1'b0;
    begin
      int n;
      n = 0;
      while (!push_element && n < 10) begin
        chk("emit_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        n++;
      end
      chk("stall_push_seen", 64'(push_element), 64'd1);
      chk("stall_push_latency", 64'(n), 64'd1);
    end
    send_line("\n");
    wait_idle();
    chk("stall_push_count", 64'(n_push - base_push), 64'd1);
    chk("stall_lines", 64'(lines_parsed), 64'd8);

    // reset in the middle of a line
    send_line("[.##.] (1,");
    pulse_reset();
    begin
      // re-check on a second asynchronous assertion sampled immediately
      send_line("[.##.] (1,");
      #2 reset = 1'b1;
      #1;
      chk("midrst_state", 64'(state_dbg), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_error", 64'(parse_error), 64'd0);
      chk("midrst_lines", 64'(lines_parsed), 64'd0);
      chk("midrst_outputs", 64'(|{button_count, flattened_buttons, flattened_machines}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
    end
    exp_q.delete();
    base_push = n_push;
    exp_q.push_back(pack_exp(vecs[0]));
    send_line({line_a, "\n"});
    wait_idle();
    chk("post_rst_push_count", 64'(n_push - base_push), 64'd1);
    chk("post_rst_lines", 64'(lines_parsed), 64'd1);
    chk("post_rst_error", 64'(parse_error), 64'd0);

    // three lines back to back with in_valid held high
    pulse_reset();
    exp_q.delete();
    base_push = n_push;
    exp_q.push_back(pack_exp(vecs[0]));
    exp_q.push_back(pack_exp(vecs[2]));
    exp_q.push_back(pack_exp(vecs[1]));
    send_line({line_a, "\n", vecs[2].s, vecs[1].s});
    wait_idle();
    chk("b2b_push_count", 64'(n_push - base_push), 64'd3);
    chk("b2b_lines", 64'(lines_parsed), 64'd3);
    chk("b2b_error", 64'(parse_error), 64'd0);
    chk("b2b_missing", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
